param_multimode_bounce_counter: RTL
===================================

Name: param_multimode_bounce_counter

Overview:
Next-generation ping-pong counter, generalised in width, step size and counting mode. Supports ping-pong, wrap-around and one-shot modes, a synchronous load, and event reporting (bounce pulse, saturating bounce count, done and config-error flags). Drives sweep and timing sequences in lab datapaths and display scanners.

Parameters:
WIDTH, 8, bit width of out, min, max, load_val
STEP_W, 4, bit width of step
CNT_W, 8, bit width of bounce_cnt

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
enable  in  1  advance counter when high; hold when low
flip  in  1  request direction reversal (modes 0/1 only)
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value loaded into out
min  in  WIDTH  lower bound (inclusive)
max  in  WIDTH  upper bound (inclusive)
step  in  STEP_W  increment magnitude; 0 treated as 1
mode  in  2  0=ping-pong, 1=wrap, 2=one-shot, 3=reserved (hold)
out  out  WIDTH  current count
direction  out  1  1=up, 0=down
bounce  out  1  registered one-cycle pulse on a turn or wrap event
bounce_cnt  out  CNT_W  saturating count of turn/wrap events
done  out  1  combinational; mode==2 and out at terminal bound for current direction
cfg_err  out  1  combinational; max<=min or out<min or out>max

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): out=min, direction=1, bounce=0, bounce_cnt=0. Reset mid-operation overrides everything.
- Priority per edge: rst > load > (!enable or cfg_err or mode==3: hold) > count.
- load: out<=load_val unclamped, direction unchanged, bounce_cnt<=0, bounce<=0. An out-of-range load raises cfg_err and the counter then holds.
- Hold: out and direction keep their values; bounce<=0.
- Effective step s = (step==0) ? 1 : step, zero-extended. All sums use WIDTH+1 bits, so there is no wrap through 0 or 2^WIDTH.
- Clipped moves: up(x) = min(x+s, max); dn(x) = max(x-s, min).
- Mode 0, ping-pong:
  - up and out==max: out<=dn(max), direction<=0, bounce event.
  - down and out==min: out<=up(min), direction<=1, bounce event.
  - Otherwise, if flip and min<out<max: direction toggles and out moves one clipped step in the new direction. No bounce event.
  - Otherwise: out moves one clipped step in the current direction.
  - The counter always lands exactly on a bound before turning.
- Mode 1, wrap:
  - flip (at any in-range out) first toggles direction.
  - Then up: out==max ? min (bounce event) : up(out).
  - Down: out==min ? max (bounce event) : dn(out).
- Mode 2, one-shot:
  - Steps with up()/dn() toward the bound. Once out reaches the bound in the current direction, out holds and done=1.
  - flip is ignored.
  - bounce pulses once, on the edge where out first reaches the bound.
- Bounce event: bounce<=1 for exactly the next cycle; bounce_cnt increments and saturates at 2^CNT_W-1.
- Mode change or min/max change takes effect at the next edge. State is not reset. If this leaves out out of range, cfg_err is set and the counter holds.
- Simultaneous flip at a bound in mode 0: the boundary rule wins and flip is ignored.

Test Plan:
1. WIDTH=8, mode0, min=3, max=7, step=1, rst then enable -> out 3,4,5,6,7,6,5,4,3,4. bounce high the cycle after 7->6 and after 3->4. bounce_cnt=2.
2. mode0, min=0, max=10, step=3 -> out 0,3,6,9,10,7,4,1,0,3. step=0 with the same bounds -> steps of 1.
3. mode0, min=0, max=10, step=1, up at out=5, flip=1 -> out=4, direction=0, bounce=0, bounce_cnt unchanged. flip at out=10 -> out=9, counted as a bounce.
4. mode1, min=2, max=5, step=2, up -> out 2,4,5,2,4, one bounce on 5->2. flip at out=4 -> out=2, direction=0, then 5.
5. mode2, min=0, max=4, step=1 -> out 0..4, then holds 4 with done=1 and a single bounce pulse. load=1, load_val=1 -> out=1, done=0, bounce_cnt=0.
6. max=3, min=5 -> cfg_err=1, out holds across 5 enabled cycles. rst=1 mid-run -> next edge out=min, direction=1, bounce_cnt=0. Saturation: CNT_W=2 reaches 3 and stays at 3.

Source files
------------

// File: rtl/param_multimode_bounce_counter.sv
// Multi-mode bounded counter: ping-pong, wrap-around and one-shot stepping between min and max.
// Reports turn/wrap events as a registered pulse plus a saturating event count.
module param_multimode_bounce_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flip,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  min,
    input  logic [WIDTH-1:0]  max,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  out,
    output logic              direction,
    output logic              bounce,
    output logic [CNT_W-1:0]  bounce_cnt,
    output logic              done,
    output logic              cfg_err
);

    // One extra bit so bound comparisons never wrap through 0 or 2^WIDTH.
    localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {
        MODE_PING    = 2'd0,
        MODE_WRAP    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    mode_e            mode_q;
    logic [EW-1:0]    s_eff, out_x, min_x, max_x, sum_up;
    logic [WIDTH-1:0] s_w, up_val, dn_val, out_nxt;
    logic             dir_nxt, dir_w, event_nxt, hold;

    assign mode_q = mode_e'(mode);
    assign s_eff  = (step == '0) ? EW'(1) : EW'(step);
    assign s_w    = WIDTH'(s_eff);
    assign out_x  = EW'(out);
    assign min_x  = EW'(min);
    assign max_x  = EW'(max);
    assign sum_up = out_x + s_eff;

    // Clipped single steps; the narrow arithmetic is only selected when it cannot overflow.
    assign up_val = (sum_up > max_x) ? max : out + s_w;
    assign dn_val = (out_x < min_x + s_eff) ? min : out - s_w;

    assign cfg_err = (max <= min) || (out < min) || (out > max);
    assign done    = (mode_q == MODE_ONESHOT) && (direction ? (out == max) : (out == min));
    assign hold    = !enable || cfg_err || (mode_q == MODE_HOLD);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        out_nxt   = out;
        dir_nxt   = direction;
        dir_w     = direction ^ flip;
        event_nxt = 1'b0;
        case (mode_q)
            MODE_PING: begin
                if (direction && out == max) begin
                    out_nxt   = dn_val;
                    dir_nxt   = 1'b0;
                    event_nxt = 1'b1;
                end else if (!direction && out == min) begin
                    out_nxt   = up_val;
                    dir_nxt   = 1'b1;
                    event_nxt = 1'b1;
                end else if (flip && out > min && out < max) begin
                    dir_nxt = ~direction;
                    out_nxt = direction ? dn_val : up_val;
                end else begin
                    out_nxt = direction ? up_val : dn_val;
                end
            end
            MODE_WRAP: begin
                dir_nxt = dir_w;
                if (dir_w) begin
                    out_nxt   = (out == max) ? min : up_val;
                    event_nxt = (out == max);
                end else begin
                    out_nxt   = (out == min) ? max : dn_val;
                    event_nxt = (out == min);
                end
            end
            MODE_ONESHOT: begin
                // Flip is ignored; the pulse fires only on the step that lands on the bound.
                if (direction && out != max) begin
                    out_nxt   = up_val;
                    event_nxt = (up_val == max);
                end else if (!direction && out != min) begin
                    out_nxt   = dn_val;
                    event_nxt = (dn_val == min);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            out        <= min;
            direction  <= 1'b1;
            bounce     <= 1'b0;
            bounce_cnt <= '0;
        end else if (load) begin
            out        <= load_val;
            bounce     <= 1'b0;
            bounce_cnt <= '0;
        end else if (hold) begin
            bounce <= 1'b0;
        end else begin
            out       <= out_nxt;
            direction <= dir_nxt;
            bounce    <= event_nxt;
            if (event_nxt && bounce_cnt != '1)
                bounce_cnt <= bounce_cnt + 1'b1;
        end
    end

endmodule
